dpy_scan_multi: RTL and testbench
=================================

Name: dpy_scan_multi

Overview:
Parametrised successor to the fixed 8-digit seven-segment scanner on the board top level. Adds:
- configurable digit count and scan rate;
- a double-buffered display image committed only at frame boundaries, so there is no tearing;
- leading-zero suppression, per-digit blank and blink masks;
- PWM brightness control.

It sits between game or debug logic (for example cursor, troop and timer fields) and the board digit/segment pins.

Parameters:
- DIGIT_CNT, 8, number of digits scanned (2..16)
- CLK_FREQ_HZ, 100_000_000, input clock frequency
- SCAN_RATE_HZ, 1000, full-frame refresh rate; digit slot = CLK_FREQ_HZ/(SCAN_RATE_HZ*DIGIT_CNT) cycles, integer, ≥ 2^PWM_BITS
- BLINK_HZ, 2, blink toggle rate; phase flips every CLK_FREQ_HZ/(2*BLINK_HZ) cycles
- PWM_BITS, 4, brightness resolution

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- number  in  4*DIGIT_CNT  hex nibbles; nibble 0 is the rightmost digit
- dp  in  DIGIT_CNT  decimal point per digit, 1 = lit
- blank_mask  in  DIGIT_CNT  1 = digit forced dark
- blink_mask  in  DIGIT_CNT  1 = digit dark during blink-off phase
- lz_suppress  in  1  enable leading-zero blanking
- brightness  in  PWM_BITS  0 = off; all-ones = full on
- update  in  1  strobe: capture all image inputs
- committed  out  1  one-cycle pulse when the image becomes active
- digit  out  DIGIT_CNT  one-hot digit select, active high
- segment  out  8  bit7 = dp, bits 6:0 = g..a, active high

Behaviour:
- Reset (asynchronous, reset_n=0): prescaler, digit index, PWM counter, blink counter and blink phase = 0 (phase 0 = visible). Pending and active images = all zero; pending flag = 0. Outputs digit=0, segment=0, committed=0.
- Prescaler: counts 0..SLOT-1; tick at SLOT-1. On tick, index advances; it wraps DIGIT_CNT-1→0. The wrap tick is frame_end.
- Capture: update=1 copies number/dp/blank_mask/blink_mask/lz_suppress into the pending image and sets the pending flag. Inputs are sampled only when update=1.
- Commit: on frame_end with pending flag set, active ← pending and the flag clears.
  - If update and frame_end coincide, active ← live inputs (bypass), the flag clears, and the pending image is loaded too.
  - committed pulses in the cycle after the active image load.
  - Repeated update before frame_end: the last one wins.
- brightness is not buffered; it takes effect immediately.
- Leading-zero suppression (active lz_suppress=1): digits from DIGIT_CNT-1 downward whose nibble is 0 are blanked until the first nonzero nibble. Digit 0 is never suppressed. dp of a suppressed digit is still shown.
- Decode: hex 0–F to segments; A,b,C,d,E,F use the standard 7-seg glyphs.
- Visibility of the current digit =
  not blank_mask
  and not (blink_mask and blink_phase=1)
  and (brightness==all-ones or pwm_cnt < brightness).
  - pwm_cnt is a free-running PWM_BITS counter reset to 0 at each tick.
  - Invisible digit → segment=0; digit one-hot is still driven, so ghosting is avoided via segments.
- Latency: digit/segment are registered, one cycle after the index/pwm state they reflect.

Decomposition:
- Package dpy_pkg holds:
  - segment encoding constants (SEG_A..SEG_G, SEG_DP);
  - function hex_to_seg(logic[3:0]) returning logic[6:0];
  - localparam derivations SLOT_CYCLES and BLINK_CYCLES, computed in the module from the package helper clog2-safe formulas.
- One sub-module, dpy_tick_gen: parametrised divider producing the slot tick and blink phase. It is instantiated once.
- All other logic is inline.

Test Plan (DIGIT_CNT=4, CLK_FREQ_HZ=1600, SCAN_RATE_HZ=100 → SLOT=4, BLINK_HZ=100 → toggle every 8, PWM_BITS=2):
- Reset then update with number=16'h12AF, brightness=3 → committed pulse after the first frame_end (cycle 16). digit cycles 0001,0010,0100,1000 every 4 clocks. segment = hex_to_seg(F), (A), (2), (1) respectively, bit7=0.
- lz_suppress=1, number=16'h0005, dp=4'b1000, update → digits 1,2 segment=0; digit 3 segment=8'h80 (dp only); digit 0 shows "5". With number=0, digit 0 shows "0".
- Update at mid-frame, then a second update with a different value before frame_end → only the second value is displayed. Exactly one committed pulse occurs. Update coincident with frame_end → the new value shows from the next frame.
- blink_mask=4'b0010 → digit 1 segment=0 during alternate 8-cycle phases; the other digits are unaffected. blank_mask=4'b0100 → digit 2 is always dark.
- brightness=1 → segments nonzero in exactly 1 of each 4 cycles per slot. brightness=0 → segment always 0. brightness=3 → always on.
- Assert reset_n low mid-slot with an active image → digit, segment and committed go to 0 immediately (asynchronously). After release, the display is blank until a new update commits.

Source files
------------

// File: rtl/dpy_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
// Segment bits are active high, bit 0 = a through bit 6 = g.
package dpy_pkg;

    localparam logic [6:0] SEG_A  = 7'h01;
    localparam logic [6:0] SEG_B  = 7'h02;
    localparam logic [6:0] SEG_C  = 7'h04;
    localparam logic [6:0] SEG_D  = 7'h08;
    localparam logic [6:0] SEG_E  = 7'h10;
    localparam logic [6:0] SEG_F  = 7'h20;
    localparam logic [6:0] SEG_G  = 7'h40;
    localparam logic [7:0] SEG_DP = 8'h80;

    function automatic int cnt_width(input int n);
        for (int w = 1; w < 31; w++) begin
            if ((1 << w) >= n) return w;
        end
        return 31;
    endfunction

    function automatic int slot_cycles(input int clk_hz,
                                       input int rate_hz,
                                       input int digits);
        return clk_hz / (rate_hz * digits);
    endfunction

    function automatic int blink_cycles(input int clk_hz,
                                        input int blink_hz);
        return clk_hz / (2 * blink_hz);
    endfunction

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
            4'h1: s = SEG_B | SEG_C;
            4'h2: s = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
            4'h3: s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
            4'h4: s = SEG_B | SEG_C | SEG_F | SEG_G;
            4'h5: s = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
            4'h6: s = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'h7: s = SEG_A | SEG_B | SEG_C;
            4'h8: s = 7'h7F;
            4'h9: s = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
            4'hA: s = SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G;
            4'hB: s = SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'hC: s = SEG_A | SEG_D | SEG_E | SEG_F;
            4'hD: s = SEG_B | SEG_C | SEG_D | SEG_E | SEG_G;
            4'hE: s = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G;
            default: s = SEG_A | SEG_E | SEG_F | SEG_G;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dpy_tick_gen.sv
// Slot tick divider and free-running blink phase generator.
// Both counters start from zero at reset, so blink phase 0 is visible.
module dpy_tick_gen
    import dpy_pkg::*;
#(
    parameter int SLOT_CYCLES  = 4,
    parameter int BLINK_CYCLES = 8
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick,
    output logic blink_phase
);

    localparam int SW = cnt_width(SLOT_CYCLES);
    localparam int BW = cnt_width(BLINK_CYCLES);

    logic [SW-1:0] slot_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_wrap;

    assign tick       = (slot_cnt == SW'(SLOT_CYCLES - 1));
    assign blink_wrap = (blink_cnt == BW'(BLINK_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            slot_cnt <= tick ? '0 : slot_cnt + 1'b1;
            if (blink_wrap) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpy_scan_multi.sv
// Multiplexed seven-segment scanner with a frame-synchronous double-buffered
// image, leading-zero blanking, blank/blink masks and PWM brightness.
module dpy_scan_multi
    import dpy_pkg::*;
#(
    parameter int DIGIT_CNT    = 8,
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int SCAN_RATE_HZ = 1000,
    parameter int BLINK_HZ     = 2,
    parameter int PWM_BITS     = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [4*DIGIT_CNT-1:0] number,
    input  logic [DIGIT_CNT-1:0]   dp,
    input  logic [DIGIT_CNT-1:0]   blank_mask,
    input  logic [DIGIT_CNT-1:0]   blink_mask,
    input  logic                   lz_suppress,
    input  logic [PWM_BITS-1:0]    brightness,
    input  logic                   update,
    output logic                   committed,
    output logic [DIGIT_CNT-1:0]   digit,
    output logic [7:0]             segment
);

    localparam int SLOT_CYCLES =
        slot_cycles(CLK_FREQ_HZ, SCAN_RATE_HZ, DIGIT_CNT);
    localparam int BLINK_CYCLES = blink_cycles(CLK_FREQ_HZ, BLINK_HZ);
    localparam int IW           = cnt_width(DIGIT_CNT);
    localparam int IMG_W        = 7 * DIGIT_CNT + 1;

    localparam logic [IW-1:0]       LAST     = IW'(DIGIT_CNT - 1);
    localparam logic [PWM_BITS-1:0] PWM_FULL = '1;

    logic                   tick;
    logic                   blink_phase;
    logic [IW-1:0]          idx;
    logic [PWM_BITS-1:0]    pwm_cnt;
    logic                   frame_end;
    logic                   do_commit;

    logic [IMG_W-1:0]       live_img;
    logic [IMG_W-1:0]       pend_img;
    logic [IMG_W-1:0]       act_img;
    logic                   pend_flag;
    logic                   act_vld;

    logic                   act_lz;
    logic [DIGIT_CNT-1:0]   act_blink;
    logic [DIGIT_CNT-1:0]   act_blank;
    logic [DIGIT_CNT-1:0]   act_dp;
    logic [4*DIGIT_CNT-1:0] act_num;

    logic [3:0]             nib;
    logic                   lz_blank;
    logic                   pwm_on;
    logic                   vis;
    logic [7:0]             seg_nxt;

    dpy_tick_gen #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLINK_CYCLES (BLINK_CYCLES)
    ) u_tick (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .blink_phase (blink_phase)
    );

    assign live_img = {lz_suppress, blink_mask, blank_mask, dp, number};
    assign {act_lz, act_blink, act_blank, act_dp, act_num} = act_img;

    assign frame_end = tick && (idx == LAST);
    assign do_commit = frame_end && (update || pend_flag);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx     <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            idx     <= (idx == LAST) ? '0 : idx + 1'b1;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // A coincident update bypasses the pending buffer straight to active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_img  <= '0;
            act_img   <= '0;
            pend_flag <= 1'b0;
            act_vld   <= 1'b0;
        end else begin
            if (update) pend_img <= live_img;
            if (do_commit) begin
                act_img <= update ? live_img : pend_img;
                act_vld <= 1'b1;
            end
            if (frame_end) pend_flag <= 1'b0;
            else if (update) pend_flag <= 1'b1;
        end
    end

    assign nib = act_num[{idx, 2'b00} +: 4];

    always_comb begin
        lz_blank = act_lz && (idx != '0);
        for (int i = 1; i < DIGIT_CNT; i++) begin
            if (i >= int'(idx) && act_num[4*i +: 4] != 4'h0)
                lz_blank = 1'b0;
        end
    end

    // Nothing is lit until the first image has been committed.
    assign pwm_on = (brightness == PWM_FULL) || (pwm_cnt < brightness);
    assign vis    = act_vld && !act_blank[idx]
                 && !(act_blink[idx] && blink_phase) && pwm_on;

    always_comb begin
        seg_nxt = 8'h00;
        if (vis) begin
            seg_nxt[7]   = act_dp[idx];
            seg_nxt[6:0] = lz_blank ? 7'h00 : hex_to_seg(nib);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit     <= '0;
            segment   <= '0;
            committed <= 1'b0;
        end else begin
            digit     <= DIGIT_CNT'(1) << idx;
            segment   <= seg_nxt;
            committed <= do_commit;
        end
    end

endmodule

// File: tb/tb_dpy_scan_multi.sv
// Scoreboard bench for dpy_scan_multi with a cycle-count reference model.
module tb_dpy_scan_multi;

    localparam int D     = 4;
    localparam int CLKHZ = 1600;
    localparam int SCAN  = 100;
    localparam int BHZ   = 100;
    localparam int PB    = 2;
    localparam int SLOT  = CLKHZ / (SCAN * D);
    localparam int BLK   = CLKHZ / (2 * BHZ);
    localparam int FRAME = SLOT * D;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [4*D-1:0] number = '0;
    logic [D-1:0]   dp = '0;
    logic [D-1:0]   blank_mask = '0;
    logic [D-1:0]   blink_mask = '0;
    logic           lz_suppress = 1'b0;
    logic [PB-1:0]  brightness = '0;
    logic           update = 1'b0;
    logic           committed;
    logic [D-1:0]   digit;
    logic [7:0]     segment;

    dpy_scan_multi #(
        .DIGIT_CNT    (D),
        .CLK_FREQ_HZ  (CLKHZ),
        .SCAN_RATE_HZ (SCAN),
        .BLINK_HZ     (BHZ),
        .PWM_BITS     (PB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .number      (number),
        .dp          (dp),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .update      (update),
        .committed   (committed),
        .digit       (digit),
        .segment     (segment)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [D-1:0] dig;
        logic [7:0]   seg;
        logic         com;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   commits_seen = 0;
    int   idle = 0;

    logic [7:0] glyph [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    // Model image: {lz, blink, blank, dp, number}
    typedef struct packed {
        logic           lz;
        logic [D-1:0]   blink;
        logic [D-1:0]   blank;
        logic [D-1:0]   dpv;
        logic [4*D-1:0] num;
    } img_t;

    img_t m_pend, m_act, m_live;
    logic m_pf, m_av;
    int   t;
    int   m_idx, m_pwm, m_hi;
    logic m_ph, m_vis, m_fe, m_com;
    obs_t m_e;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t = 0;
            m_pf = 1'b0;
            m_av = 1'b0;
            m_pend = '0;
            m_act = '0;
            exp_q.delete();
        end else begin
            m_idx = (t / SLOT) % D;
            m_pwm = (t % SLOT) % (1 << PB);
            m_ph  = ((t / BLK) % 2) == 1;
            m_hi  = -1;
            for (int i = 0; i < D; i++)
                if (m_act.num[4*i +: 4] != 4'h0) m_hi = i;
            m_vis = m_av && !m_act.blank[m_idx]
                 && !(m_act.blink[m_idx] && m_ph)
                 && (brightness == 2'd3 || m_pwm < int'(brightness));
            m_e.dig = D'(1) << m_idx;
            if (!m_vis)
                m_e.seg = 8'h00;
            else if (m_act.lz && m_idx > m_hi && m_idx != 0)
                m_e.seg = {m_act.dpv[m_idx], 7'h00};
            else
                m_e.seg = glyph[m_act.num[4*m_idx +: 4]]
                        | {m_act.dpv[m_idx], 7'h00};
            m_fe  = (t % FRAME) == FRAME - 1;
            m_com = m_fe && (update || m_pf);
            m_e.com = m_com;
            exp_q.push_back(m_e);
            m_live = {lz_suppress, blink_mask, blank_mask, dp, number};
            if (m_com) begin
                m_act = update ? m_live : m_pend;
                m_av  = 1'b1;
            end
            if (update) m_pend = m_live;
            if (m_fe) m_pf = 1'b0;
            else if (update) m_pf = 1'b1;
            t++;
        end
    end

    obs_t got, want;

    always @(negedge clk) begin
        got = {digit, segment, committed};
        if (reset_n && committed) commits_seen++;
        if (!reset_n) begin
            checks++;
            if (got != '0) begin
                failures++;
                $display("FAIL reset_outs: got %h required 0", got);
            end
        end else if (exp_q.size() > 0) begin
            idle = 0;
            want = exp_q.pop_front();
            checks++;
            if (got != want) begin
                failures++;
                $display("FAIL scan t=%0d: got dig=%b seg=%h com=%b required dig=%b seg=%h com=%b",
                         t, got.dig, got.seg, got.com,
                         want.dig, want.seg, want.com);
            end
        end else begin
            idle++;
            if (idle > 3) begin
                checks++;
                failures++;
                idle = 0;
                $display("FAIL monitor_timeout: got no output required one per cycle");
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic upd(input logic [4*D-1:0] n, input logic [D-1:0] d,
                       input logic lz);
        number = n;
        dp = d;
        lz_suppress = lz;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (t % FRAME == p) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL wait_phase: got no phase %0d required within %0d cycles",
                 p, 2 * FRAME);
    endtask

    function automatic logic [15:0] rnd_num();
        logic [15:0] v;
        v = 16'($urandom);
        for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'h0;
        return v;
    endfunction

    int c0;

    initial begin
        cycles(3);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        brightness = 2'd3;
        wait_phase(2);
        upd(16'h12AF, 4'b0000, 1'b0);
        cycles(40);

        upd(16'h0005, 4'b1000, 1'b1);
        cycles(2 * FRAME);
        upd(16'h0000, 4'b0000, 1'b1);
        cycles(2 * FRAME);
        upd(16'h0A00, 4'b0101, 1'b1);
        cycles(2 * FRAME);

        wait_phase(4);
        c0 = commits_seen;
        upd(16'h1111, 4'b0001, 1'b0);
        cycles(3);
        upd(16'h2345, 4'b0010, 1'b0);
        wait_phase(3);
        checks++;
        if (commits_seen - c0 != 1) begin
            failures++;
            $display("FAIL one_commit: got %0d pulses required 1",
                     commits_seen - c0);
        end
        cycles(FRAME);

        wait_phase(15);
        upd(16'h6789, 4'b0000, 1'b0);
        cycles(2 * FRAME);

        blink_mask = 4'b0010;
        blank_mask = 4'b0100;
        upd(16'h8888, 4'b1111, 1'b0);
        cycles(3 * FRAME);
        blink_mask = 4'b1111;
        upd(16'h8888, 4'b1111, 1'b0);
        cycles(3 * FRAME);
        blink_mask = 4'b0000;
        blank_mask = 4'b0000;
        upd(16'hC3E7, 4'b0000, 1'b0);

        for (int b = 0; b < 4; b++) begin
            brightness = PB'(b);
            cycles(2 * FRAME);
        end

        for (int i = 0; i < 400; i++) begin
            number      = rnd_num();
            dp          = D'($urandom);
            blank_mask  = ($urandom_range(0, 3) == 0) ? D'($urandom) : '0;
            blink_mask  = D'($urandom);
            lz_suppress = 1'($urandom);
            update      = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) brightness = PB'($urandom);
            @(negedge clk);
        end
        update = 1'b0;

        brightness = 2'd3;
        blank_mask = '0;
        blink_mask = '0;
        upd(16'h8888, 4'b1111, 1'b0);
        cycles(FRAME + 5);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({digit, segment, committed} != '0) begin
            failures++;
            $display("FAIL async_reset: got dig=%b seg=%h com=%b required 0",
                     digit, segment, committed);
        end
        cycles(2);
        @(posedge clk);
        #2 reset_n = 1'b1;
        cycles(3 * FRAME);
        upd(16'h4B0D, 4'b0100, 1'b0);
        cycles(2 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
